// File: rtl/ysyx_25010008_axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one-slave AXI4-lite arbiter.
// One transaction at a time, round-robin on simultaneous requests.
module ysyx_25010008_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [2:0]          ifu_arsize,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    input  logic                ifu_rready,

    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [2:0]          lsu_arsize,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_rready,
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [2:0]          lsu_awsize,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,

    output logic                s_arvalid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [2:0]          s_arsize,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                s_rready,
    output logic                s_awvalid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [2:0]          s_awsize,
    input  logic                s_awready,
    output logic                s_wvalid,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic [1:0]          s_bresp,
    output logic                s_bready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IFU_R = 2'd1;
    localparam logic [1:0] LSU_R = 2'd2;
    localparam logic [1:0] LSU_W = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;
    logic       last_nxt;
    logic       ifu_req;
    logic       lsu_req;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        ifu_req   = ifu_arvalid;
        lsu_req   = lsu_awvalid | lsu_arvalid;
        case (state)
            IDLE: begin
                // LSU wins when alone, or on a tie when IFU was served last
                if (lsu_req && (!ifu_req || !last)) begin
                    state_nxt = lsu_awvalid ? LSU_W : LSU_R;
                    last_nxt  = 1'b1;
                end else if (ifu_req) begin
                    state_nxt = IFU_R;
                    last_nxt  = 1'b0;
                end
            end
            IFU_R, LSU_R: if (s_rvalid && s_rready) state_nxt = IDLE;
            LSU_W:        if (s_bvalid && s_bready) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Data paths are muxed/forwarded unconditionally; only handshakes are gated
    assign s_araddr  = (state == LSU_R) ? lsu_araddr : ifu_araddr;
    assign s_arsize  = (state == LSU_R) ? lsu_arsize : ifu_arsize;
    assign s_awaddr  = lsu_awaddr;
    assign s_awsize  = lsu_awsize;
    assign s_wdata   = lsu_wdata;
    assign s_wstrb   = lsu_wstrb;
    assign ifu_rdata = s_rdata;
    assign ifu_rresp = s_rresp;
    assign lsu_rdata = s_rdata;
    assign lsu_rresp = s_rresp;
    assign lsu_bresp = s_bresp;

    always_comb begin
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        case (state)
            IFU_R: begin
                s_arvalid   = ifu_arvalid;
                ifu_arready = s_arready;
                ifu_rvalid  = s_rvalid;
                s_rready    = ifu_rready;
            end
            LSU_R: begin
                s_arvalid   = lsu_arvalid;
                lsu_arready = s_arready;
                lsu_rvalid  = s_rvalid;
                s_rready    = lsu_rready;
            end
            LSU_W: begin
                s_awvalid   = lsu_awvalid;
                lsu_awready = s_awready;
                s_wvalid    = lsu_wvalid;
                lsu_wready  = s_wready;
                lsu_bvalid  = s_bvalid;
                s_bready    = lsu_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25010008_axi_arbiter.sv
// Directed bench for ysyx_25010008_axi_arbiter; the bench plays both masters and the slave.
module tb_ysyx_25010008_axi_arbiter;

    logic        clock;
    logic        reset;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_araddr, ifu_rdata;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_araddr, lsu_rdata;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_awaddr, lsu_wdata;
    logic [2:0]  lsu_awsize;
    logic [3:0]  lsu_wstrb;
    logic [1:0]  lsu_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [2:0]  s_arsize;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_awaddr, s_wdata;
    logic [2:0]  s_awsize;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;

    int unsigned errors = 0;
    int unsigned checks = 0;

    ysyx_25010008_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize),
        .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wready(lsu_wready), .lsu_bvalid(lsu_bvalid),
        .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arsize(s_arsize),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_bresp(s_bresp), .s_bready(s_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Called during an IDLE cycle with the request already driven.
    task automatic serve_read(input logic sel_lsu, input logic [31:0] addr, input int unsigned lat,
                              input logic [31:0] data, input logic [1:0] resp);
        #1 check("idle_arvalid", s_arvalid, 1'b0);
        cyc();
        s_arready = 1'b1;
        #1;
        check("grant_arvalid", s_arvalid, 1'b1);
        check("grant_araddr", s_araddr, addr);
        check("grant_arsize", s_arsize, 3'd2);
        check("ifu_arready", ifu_arready, !sel_lsu);
        check("lsu_arready", lsu_arready, sel_lsu);
        for (int unsigned i = 1; i < lat; i++) begin
            cyc();
            s_arready = 1'b0;
            #1 check("r_wait_rvalid", {ifu_rvalid, lsu_rvalid}, 2'b00);
        end
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = data;
        s_rresp   = resp;
        #1;
        check("sel_rvalid", sel_lsu ? lsu_rvalid : ifu_rvalid, 1'b1);
        check("other_rvalid", sel_lsu ? ifu_rvalid : lsu_rvalid, 1'b0);
        check("sel_rdata", sel_lsu ? lsu_rdata : ifu_rdata, data);
        check("sel_rresp", sel_lsu ? lsu_rresp : ifu_rresp, resp);
        check("s_rready", s_rready, 1'b1);
        cyc();
        s_rvalid = 1'b0;
        #1;
        check("done_rready", s_rready, 1'b0);
        check("done_arvalid", s_arvalid, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arsize = 3'd2; ifu_rready = 1'b1;
        lsu_arvalid = 1'b0; lsu_araddr = 32'h8000_1000; lsu_arsize = 3'd2; lsu_rready = 1'b1;
        lsu_awvalid = 1'b0; lsu_awaddr = '0; lsu_awsize = 3'd2;
        lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0; lsu_bready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;

        // Reset held with a request pending: no handshake outputs
        repeat (2) @(posedge clock);
        #3;
        check("rst_arvalid", s_arvalid, 1'b0);
        check("rst_ifu_arready", ifu_arready, 1'b0);
        reset = 1'b1;
        #1 check("post_rst_arvalid", s_arvalid, 1'b0);

        // Conflict from reset: LSU first, then IFU while both keep requesting
        lsu_arvalid = 1'b1;
        serve_read(1'b1, 32'h8000_1000, 1, 32'hA5A5_5A5A, 2'b00);
        serve_read(1'b0, 32'h3000_0000, 1, 32'h0BAD_F00D, 2'b00);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        cyc();
        #1 check("withdrawn_no_grant", {s_arvalid, s_awvalid}, 2'b00);

        // Single IFU read, slave answers 3 cycles after the grant
        ifu_arvalid = 1'b1;
        serve_read(1'b0, 32'h3000_0000, 3, 32'hDEAD_BEEF, 2'b00);
        ifu_arvalid = 1'b0;

        // LSU store with IFU stalled behind it
        lsu_awvalid = 1'b1; lsu_awaddr = 32'h8000_0004;
        lsu_wvalid = 1'b1; lsu_wdata = 32'h1122_3344; lsu_wstrb = 4'hF;
        ifu_arvalid = 1'b1;
        #1 check("w_idle_awvalid", {s_awvalid, s_wvalid}, 2'b00);
        cyc();
        s_awready = 1'b1; s_wready = 1'b1;
        #1;
        check("w_aw_w_valid", {s_awvalid, s_wvalid}, 2'b11);
        check("w_awaddr", s_awaddr, 32'h8000_0004);
        check("w_wdata", s_wdata, 32'h1122_3344);
        check("w_wstrb", s_wstrb, 4'hF);
        check("w_readies", {lsu_awready, lsu_wready}, 2'b11);
        check("w_ifu_stalled", {s_arvalid, ifu_arready}, 2'b00);
        cyc();
        s_awready = 1'b0; s_wready = 1'b0;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        #1;
        check("w_bvalid", lsu_bvalid, 1'b1);
        check("w_bresp", lsu_bresp, 2'b00);
        check("w_bready", s_bready, 1'b1);
        check("w_ifu_stalled2", {s_arvalid, ifu_arready}, 2'b00);
        cyc();
        s_bvalid = 1'b0;
        #1 check("w_done_bready", s_bready, 1'b0);
        serve_read(1'b0, 32'h3000_0000, 1, 32'h1234_5678, 2'b00);
        ifu_arvalid = 1'b0;

        // LSU read with SLVERR
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_2000;
        serve_read(1'b1, 32'h8000_2000, 1, 32'hCAFE_F00D, 2'b10);
        lsu_arvalid = 1'b0;
        cyc();
        #1 check("err_idle_arvalid", s_arvalid, 1'b0);

        // IFU pulses during LSU_R, then re-requests
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_3000;
        #1 check("p_idle_arvalid", s_arvalid, 1'b0);
        cyc();
        s_arready = 1'b1; ifu_arvalid = 1'b1;
        #1;
        check("p_lsu_araddr", s_araddr, 32'h8000_3000);
        check("p_ifu_arready", ifu_arready, 1'b0);
        cyc();
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
        #1 check("p_rvalid", {lsu_rvalid, ifu_rvalid}, 2'b10);
        cyc();
        s_rvalid = 1'b0;
        #1 check("p_idle_rready", s_rready, 1'b0);
        cyc();
        #1 check("p_no_spurious", {s_arvalid, ifu_arready}, 2'b00);
        ifu_arvalid = 1'b1;
        serve_read(1'b0, 32'h3000_0000, 1, 32'h7777_0001, 2'b00);
        ifu_arvalid = 1'b0;

        // Reset asserted mid-write abandons the transaction
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1; lsu_awaddr = 32'h8000_0008;
        cyc();
        #1 check("rw_awvalid", s_awvalid, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("rw_valids_drop", {s_awvalid, s_wvalid, s_arvalid}, 3'b000);
        check("rw_readies_drop", {lsu_awready, lsu_wready, s_bready}, 3'b000);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_4000;
        cyc();
        #1 check("rw_in_reset", s_arvalid, 1'b0);
        reset = 1'b1;
        #1 check("rw_post_release", s_arvalid, 1'b0);
        serve_read(1'b1, 32'h8000_4000, 1, 32'h0000_0042, 2'b00);
        lsu_arvalid = 1'b0;
        serve_read(1'b0, 32'h3000_0000, 1, 32'h0000_0043, 2'b00);
        ifu_arvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
